muldiv_unit: RTL and testbench

Multi-cycle integer multiply/divide unit sitting directly downstream of the CPU register file. It takes the two read-port values (RD1 → `a`, RD2 → `b`) on a start strobe and iterates one bit per clock. It writes a HI/LO result pair, which is held until the next operation completes. The CPU stalls on `busy` and consumes `hi`/`lo` on `done`.

---
 rtl/muldiv_pkg.sv | 18 +
 rtl/muldiv_signfix.sv | 30 +++
 rtl/muldiv_unit.sv | 178 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit.
// The divide datapath is compiled in only when MULDIV_DIV_EN is defined.
package muldiv_pkg;

    localparam int MULDIV_WIDTH = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional negation of the raw magnitude result: product, or quotient/remainder.
// Sign flags arrive already qualified, so they are only ever set for signed ops.
module muldiv_signfix
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic               is_div_i,
    input  logic               neg_a_i,
    input  logic               neg_b_i,
    input  logic [2*WIDTH-1:0] acc_i,
    output logic [WIDTH-1:0]   hi_o,
    output logic [WIDTH-1:0]   lo_o
);

    logic               neg_res;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    assign neg_res = neg_a_i ^ neg_b_i;
    assign prod    = neg_res ? -acc_i : acc_i;
    assign quo     = neg_res ? -acc_i[WIDTH-1:0] : acc_i[WIDTH-1:0];
    // Remainder follows the dividend's sign.
    assign rem     = neg_a_i ? -acc_i[2*WIDTH-1:WIDTH] : acc_i[2*WIDTH-1:WIDTH];

    assign hi_o = is_div_i ? rem : prod[2*WIDTH-1:WIDTH];
    assign lo_o = is_div_i ? quo : prod[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle integer multiply/divide, one bit per clock (MULDIV_DIV_EN enables divide).
//   state | meaning
//   IDLE  | waiting for start; latches op, sign flags and operand magnitudes
//   CALC  | WIDTH shift-add or restoring-divide iterations
//   DONE  | result registered, done pulsed, returns to IDLE
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div_zero_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    muldiv_state_t      state_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   mag_a_q;
    logic               neg_a_q;
    logic               neg_b_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               div_zero_q;

    logic               is_div_req;
    logic               is_signed_req;
    logic               neg_a_req;
    logic               neg_b_req;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic               sf_is_div;
    logic [WIDTH-1:0]   sf_hi;
    logic [WIDTH-1:0]   sf_lo;

    assign is_div_req    = (op_i == OP_DIV) || (op_i == OP_DIVU);
    assign is_signed_req = (op_i == OP_MULT) || (op_i == OP_DIV);
    assign neg_a_req     = is_signed_req & a_i[WIDTH-1];
    assign neg_b_req     = is_signed_req & b_i[WIDTH-1];
    // Most-negative input negates to itself, which is the correct unsigned magnitude.
    assign abs_a         = neg_a_req ? -a_i : a_i;
    assign abs_b         = neg_b_req ? -b_i : b_i;

    // Multiplier sits in the low half and shifts out as the product shifts in.
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_a_q} : '0);

`ifdef MULDIV_DIV_EN
    logic               is_div_q;
    logic [WIDTH-1:0]   mag_b_q;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     rem_sub;
    logic               q_bit;

    // Remainder in the high half, dividend shifting out / quotient shifting in below.
    assign rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
    assign rem_sub = rem_sh - {1'b0, mag_b_q};
    assign q_bit   = ~rem_sub[WIDTH];

    always_comb begin
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        if (is_div_q) begin
            acc_d = {(q_bit ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], q_bit};
        end
    end

    assign sf_is_div = is_div_q;
`else
    assign acc_d     = {mul_sum, acc_q[WIDTH-1:1]};
    assign sf_is_div = 1'b0;
`endif

    muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
        .is_div_i (sf_is_div),
        .neg_a_i  (neg_a_q),
        .neg_b_i  (neg_b_q),
        .acc_i    (acc_d),
        .hi_o     (sf_hi),
        .lo_o     (sf_lo)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            mag_a_q    <= '0;
            neg_a_q    <= 1'b0;
            neg_b_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div_q   <= 1'b0;
            mag_b_q    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        busy_q     <= 1'b1;
                        div_zero_q <= 1'b0;
                        cnt_q      <= '0;
                        neg_a_q    <= neg_a_req;
                        neg_b_q    <= neg_b_req;
                        if (is_div_req) begin
`ifdef MULDIV_DIV_EN
                            is_div_q <= 1'b1;
                            if (b_i == '0) begin
                                hi_q       <= a_i;
                                lo_q       <= '1;
                                div_zero_q <= 1'b1;
                                done_q     <= 1'b1;
                                state_q    <= DONE;
                            end else begin
                                mag_b_q <= abs_b;
                                acc_q   <= {{WIDTH{1'b0}}, abs_a};
                                state_q <= CALC;
                            end
`else
                            hi_q    <= '0;
                            lo_q    <= '0;
                            done_q  <= 1'b1;
                            state_q <= DONE;
`endif
                        end else begin
`ifdef MULDIV_DIV_EN
                            is_div_q <= 1'b0;
`endif
                            mag_a_q <= abs_a;
                            acc_q   <= {{WIDTH{1'b0}}, abs_b};
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    // Final iteration: register the sign-corrected result on the way into DONE.
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        hi_q    <= sf_hi;
                        lo_q    <= sf_lo;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;
    assign div_zero_o = div_zero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit; expectations follow MULDIV_DIV_EN when defined.
`timescale 1ns/1ps
module tb_muldiv_unit;

    localparam int W = 32;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
        int          cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          busy;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic          dz;

    exp_t          sbq[$];
    int            n_vec = 0;
    int            n_err = 0;
    int            ndone = 0;
    int            cyc   = 0;
    logic [31:0]   prev_hi = '0;
    logic [31:0]   prev_lo = '0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .start_i    (start),
        .op_i       (op),
        .a_i        (a),
        .b_i        (b),
        .busy_o     (busy),
        .done_o     (done),
        .hi_o       (hi),
        .lo_o       (lo),
        .div_zero_o (dz)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every done pulse pops one expected result.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("unexp_done", 64'(done), 64'(0));
            end else begin
                e = sbq.pop_front();
                chk("res_hi", 64'(hi), 64'(e.hi));
                chk("res_lo", 64'(lo), 64'(e.lo));
                chk("res_dz", 64'(dz), 64'(e.dz));
                chk("latency", 64'(cyc - e.cyc), 64'(e.lat));
            end
            ndone <= ndone + 1;
        end
    end

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t r;
        logic signed [63:0] sx, sy, q, m;
        logic [63:0] p;
        r.hi = '0; r.lo = '0; r.dz = 1'b0; r.lat = W + 1; r.cyc = 0;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        p  = '0; q = '0; m = '0;
        case (o)
            2'b00: begin p = sx * sy; r.hi = p[63:32]; r.lo = p[31:0]; end
            2'b01: begin p = {32'b0, x} * {32'b0, y}; r.hi = p[63:32]; r.lo = p[31:0]; end
            default: begin
`ifdef MULDIV_DIV_EN
                if (y == 0) begin
                    r.hi = x; r.lo = '1; r.dz = 1'b1; r.lat = 1;
                end else if (o == 2'b10) begin
                    q = sx / sy; m = sx % sy;
                    r.hi = m[31:0]; r.lo = q[31:0];
                end else begin
                    p = {32'b0, x} / {32'b0, y}; r.lo = p[31:0];
                    p = {32'b0, x} % {32'b0, y}; r.hi = p[31:0];
                end
`else
                r.lat = 1;
`endif
            end
        endcase
        return r;
    endfunction

    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input exp_t e_in, input bit rep);
        exp_t e;
        exp_t t;
        int base;
        int rel;
        e = e_in;
        base = ndone;
        op = o; a = x; b = y; start = 1'b1;
        e.cyc = cyc;
        sbq.push_back(e);
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
        rel = 1;
        while (rel < 60) begin
            @(negedge clk); #1;
            if (rel == 1) begin
                chk("busy_c1", 64'(busy), 64'(1));
                if (e.lat > 1) begin
                    chk("hold_hi", 64'(hi), 64'(prev_hi));
                    chk("hold_lo", 64'(lo), 64'(prev_lo));
                    chk("dz_clear", 64'(dz), 64'(0));
                end
            end
            if (ndone != base) break;
            if (rep && rel == 5) begin
                start = 1'b1; a = $urandom; b = $urandom; op = 2'($urandom);
            end
            @(posedge clk); #1;
            start = 1'b0;
            rel++;
        end
        if (ndone == base) begin
            chk("done_timeout", 64'(ndone - base), 64'(1));
            if (sbq.size() > 0) t = sbq.pop_front();
        end
        if (rep) begin
            start = 1'b1; a = $urandom; b = $urandom; op = 2'($urandom);
        end
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk); #1;
        chk("busy_drop", 64'(busy), 64'(0));
        if (rep) begin
            repeat (40) @(posedge clk);
            #1;
            chk("extra_done", 64'(ndone - base), 64'(1));
        end
        prev_hi = e.hi;
        prev_lo = e.lo;
    endtask

    // Directed vector with expectations written for the divider-enabled build.
    task automatic run_dir(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] h, input logic [31:0] l, input logic z, input bit rep);
        exp_t e;
        e.hi = h; e.lo = l; e.dz = z; e.lat = W + 1; e.cyc = 0;
        if (o[1]) begin
`ifdef MULDIV_DIV_EN
            if (y == 0) e.lat = 1;
`else
            e.hi = '0; e.lo = '0; e.dz = 1'b0; e.lat = 1;
`endif
        end
        do_op(o, x, y, e, rep);
    endtask

    initial begin
        int base;
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_hi",   64'(hi),   64'(0));
        chk("rst_lo",   64'(lo),   64'(0));
        chk("rst_dz",   64'(dz),   64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_dir(2'b01, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0);
        run_dir(2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b0);
        run_dir(2'b10, 32'hFFFFFFEF, 32'd5,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 1'b0);
        run_dir(2'b11, 32'd17,       32'd11,       32'd6,        32'd1,        1'b0, 1'b0);
        run_dir(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0);
        run_dir(2'b11, 32'd9,        32'd0,        32'd9,        32'hFFFFFFFF, 1'b1, 1'b0);
        run_dir(2'b01, 32'd7,        32'd6,        32'd0,        32'd42,       1'b0, 1'b0);
        run_dir(2'b10, 32'd9,        32'd3,        32'd0,        32'd3,        1'b0, 1'b0);
        run_dir(2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0);
        run_dir(2'b10, 32'd7,        32'd0,        32'd7,        32'hFFFFFFFF, 1'b1, 1'b0);
        run_dir(2'b10, 32'd17,       32'hFFFFFFFB, 32'd2,        32'hFFFFFFFD, 1'b0, 1'b0);
        run_dir(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 1'b0);
        run_dir(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);
        run_dir(2'b01, 32'd3,        32'd5,        32'd0,        32'd15,       1'b0, 1'b0);
        // Start re-pulsed in cycles 5 and 33 must be ignored.
        run_dir(2'b01, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b1);

        // Reset in cycle 10 of a running multiply aborts with no done.
        op = 2'b01; a = 32'd5; b = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        base = ndone;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_done", 64'(done), 64'(0));
        chk("arst_hi",   64'(hi),   64'(0));
        chk("arst_lo",   64'(lo),   64'(0));
        chk("arst_dz",   64'(dz),   64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("arst_no_done", 64'(ndone - base), 64'(0));
        chk("arst_idle",    64'(busy),         64'(0));
        prev_hi = '0;
        prev_lo = '0;

        for (int i = 0; i < 16; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i % 4 == 2) ? 32'($urandom_range(0, 3)) : $urandom;
            do_op(ro, ra, rb, model(ro, ra, rb), 1'b0);
        end

        if (sbq.size() != 0) chk("sb_empty", 64'(sbq.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
